// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared FSM state, control bundle and hazard helper for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_bubble;
    } pipeline_control_t;

    localparam pipeline_control_t CTRL_HOLD     = pipeline_control_t'(6'b000000);
    localparam pipeline_control_t CTRL_RUN      = pipeline_control_t'(6'b111100);
    localparam pipeline_control_t CTRL_LOAD_USE = pipeline_control_t'(6'b001101);
    localparam pipeline_control_t CTRL_FLUSH    = pipeline_control_t'(6'b111111);

    function automatic logic load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic uses_rs1, input logic uses_rs2,
                                      input logic [4:0] rd, input logic mem_read);
        return mem_read && rd != 5'd0 && ((uses_rs1 && rs1 == rd) || (uses_rs2 && rs2 == rd));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != '1)
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: Mealy stall/flush control for load-use, taken-branch and memory-wait hazards,
// with a memory-timeout error state and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_ifid_rs1,
    input  logic [4:0]       i_ifid_rs2,
    input  logic             i_ifid_uses_rs1,
    input  logic             i_ifid_uses_rs2,
    input  logic [4:0]       i_idex_rd,
    input  logic             i_idex_mem_read,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    input  logic             i_clear_counters,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_write,
    output logic             o_exmem_write,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count,
    output logic             o_busy,
    output logic             o_err
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    hz_state_e         r_state, w_next;
    logic [WW-1:0]     r_wait, w_wait_next, w_wait_inc;
    logic              r_err, w_stall;
    pipeline_control_t w_hz, w_ctrl;

    assign w_stall    = i_mem_req & ~i_mem_ready;
    assign w_wait_inc = r_wait + WW'(1);
    // A taken branch squashes the dependent instruction, so it outranks load-use.
    assign w_hz = i_ex_branch_taken ? CTRL_FLUSH :
                  load_use(i_ifid_rs1, i_ifid_rs2, i_ifid_uses_rs1, i_ifid_uses_rs2,
                           i_idex_rd, i_idex_mem_read) ? CTRL_LOAD_USE : CTRL_RUN;

    // The wait count includes the RUN cycle that first sees the stall.
    always_comb begin
        w_ctrl      = CTRL_HOLD;
        w_next      = r_state;
        w_wait_next = r_wait;
        if (r_state != ERROR) begin
            if (w_stall) begin
                w_next      = (w_wait_inc == WW'(MAX_WAIT)) ? ERROR : MEM_WAIT;
                w_wait_next = w_wait_inc;
            end else begin
                w_ctrl      = w_hz;
                w_next      = RUN;
                w_wait_next = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            r_err   <= r_err | (w_next == ERROR);
        end
    end

    assign o_pc_write    = i_rst_n & w_ctrl.pc_write;
    assign o_ifid_write  = i_rst_n & w_ctrl.ifid_write;
    assign o_idex_write  = i_rst_n & w_ctrl.idex_write;
    assign o_exmem_write = i_rst_n & w_ctrl.exmem_write;
    assign o_ifid_flush  = i_rst_n & w_ctrl.ifid_flush;
    assign o_idex_bubble = i_rst_n & w_ctrl.idex_bubble;
    assign o_busy        = i_rst_n & (r_state != RUN);
    assign o_err         = r_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clear_counters),
        .i_inc   (~o_pc_write),
        .o_cnt   (o_stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clear_counters),
        .i_inc   (o_ifid_flush),
        .o_cnt   (o_flush_count)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for the hazard controller; expected control vectors are
// queued when each cycle is driven and compared mid-cycle, counters checked against a saturating model.
module tb_pipeline_hazard_ctrl;
    localparam int CW = 4;
    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, busy, err}
    localparam logic [7:0] NORM  = 8'b1111_0000;
    localparam logic [7:0] LU    = 8'b0011_0100;
    localparam logic [7:0] BR    = 8'b1111_1100;
    localparam logic [7:0] STL   = 8'b0000_0000;
    localparam logic [7:0] WAIT  = 8'b0000_0010;
    localparam logic [7:0] ERR   = 8'b0000_0011;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, mr, br, req, rdy, clr;
    logic          pc_w, ifid_w, idex_w, exmem_w, flush, bubble, busy, err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int            checks = 0, errors = 0;
    logic [7:0]    exp_q[$];
    logic [CW-1:0] m_stall = '0, m_flush = '0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ifid_rs1(rs1), .i_ifid_rs2(rs2), .i_ifid_uses_rs1(u1), .i_ifid_uses_rs2(u2),
        .i_idex_rd(rd), .i_idex_mem_read(mr), .i_ex_branch_taken(br),
        .i_mem_req(req), .i_mem_ready(rdy), .i_clear_counters(clr),
        .o_pc_write(pc_w), .o_ifid_write(ifid_w), .o_idex_write(idex_w), .o_exmem_write(exmem_w),
        .o_ifid_flush(flush), .o_idex_bubble(bubble),
        .o_stall_count(stall_cnt), .o_flush_count(flush_cnt),
        .o_busy(busy), .o_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; mr = 1'b0; br = 1'b0;
        req = 1'b0; rdy = 1'b0; clr = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "_ctl"}, 32'({pc_w, ifid_w, idex_w, exmem_w, flush, bubble, busy, err}), 32'(e));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        m_stall = clr ? '0 : (!e[7] && m_stall != '1) ? m_stall + 1'b1 : m_stall;
        m_flush = clr ? '0 : (e[3] && m_flush != '1) ? m_flush + 1'b1 : m_flush;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_ctl"}, 32'({pc_w, ifid_w, idex_w, exmem_w, flush, bubble, busy, err}), 32'(0));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(0));
        chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(0));
        m_stall = '0;
        m_flush = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rs1 = 5'd3; rd = 5'd9; u1 = 1'b1;
        #1;
        chk("rst_ctl", 32'({pc_w, ifid_w, idex_w, exmem_w, flush, bubble, busy, err}), 32'(0));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));
        chk("rst_flush_cnt", 32'(flush_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        cyc("idle0", NORM);
        cyc("idle1", NORM);
        // load-use on rs1
        mr = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1;
        cyc("lu_rs1", LU);
        idle();
        cyc("after_lu", NORM);
        // rd = x0 never stalls; unused operand never stalls
        mr = 1'b1; rd = 5'd0; rs1 = 5'd0; u1 = 1'b1;
        cyc("lu_x0", NORM);
        mr = 1'b1; rd = 5'd7; rs1 = 5'd7; u1 = 1'b0;
        cyc("lu_unused", NORM);
        mr = 1'b0; rd = 5'd7; rs1 = 5'd7; u1 = 1'b1;
        cyc("no_load", NORM);
        mr = 1'b1; rd = 5'd7; rs1 = 5'd1; rs2 = 5'd7; u1 = 1'b1; u2 = 1'b1;
        cyc("lu_rs2", LU);
        // branch overrides load-use
        br = 1'b1;
        cyc("br_lu", BR);
        idle();
        cyc("after_br", NORM);
        // memory stall 3 cycles (branch ignored during stall), ready cycle honours branch
        req = 1'b1; br = 1'b1;
        cyc("mem1", STL);
        br = 1'b0;
        cyc("mem2", WAIT);
        cyc("mem3", WAIT);
        rdy = 1'b1; br = 1'b1;
        cyc("mem_rdy", BR | 8'b0000_0010);
        idle();
        cyc("mem_back", NORM);
        // 14 low cycles keep waiting, the 15th trips the timeout
        req = 1'b1;
        cyc("to_first", STL);
        for (int i = 1; i < 15; i++) cyc("to_wait", WAIT);
        cyc("to_err0", ERR);
        idle();
        cyc("to_err1", ERR);
        rdy = 1'b1; req = 1'b1; br = 1'b1;
        cyc("to_err2", ERR);
        idle();
        reset_pulse("rst_err");
        cyc("post_err", NORM);
        // no leftover wait count: a fresh 1-cycle stall returns cleanly
        req = 1'b1;
        cyc("fresh_stall", STL);
        rdy = 1'b1;
        cyc("fresh_rdy", NORM | 8'b0000_0010);
        idle();
        cyc("fresh_run", NORM);
        // saturate both counters
        mr = 1'b1; rd = 5'd4; rs1 = 5'd4; u1 = 1'b1;
        for (int i = 0; i < 18; i++) cyc("sat_stall", LU);
        idle();
        br = 1'b1;
        for (int i = 0; i < 18; i++) cyc("sat_flush", BR);
        idle();
        cyc("sat_hold", NORM);
        chk("sat_stall_max", 32'(stall_cnt), 32'(15));
        chk("sat_flush_max", 32'(flush_cnt), 32'(15));
        // clear while both counters would increment
        mr = 1'b1; rd = 5'd4; rs1 = 5'd4; u1 = 1'b1; clr = 1'b1;
        cyc("clr_stall", LU);
        idle();
        br = 1'b1; clr = 1'b1;
        cyc("clr_flush", BR);
        idle();
        cyc("clr_zero", NORM);
        cyc("clr_after", NORM);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
